dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 10, data memory word-address width.
REQ-002 Parameter: DATA_W, 32, data word width.
REQ-003 Clocking: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-004 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: core_req / core_we  input  1 / 1  core access request / write-not-read.
REQ-007 Port: core_addr / core_wdata  input  ADDR_W / DATA_W  core address / write data.
REQ-008 Port: core_gnt / core_rvalid  output  1 / 1  core grant pulse / read-data-valid pulse.
REQ-009 Port: core_rdata  output  DATA_W  core read data, meaningful only while core_rvalid=1.
REQ-010 Port: ext_req / ext_we, ext_addr / ext_wdata  input  1 / 1, ADDR_W / DATA_W  external loader port, same meaning as core.
REQ-011 Port: ext_gnt / ext_rvalid / ext_rdata  output  1 / 1 / DATA_W  external loader grant, valid and data.
REQ-012 Port: mem_address / mem_data / mem_wren  output  ADDR_W / DATA_W / 1  to single-port synchronous data memory.
REQ-013 Port: mem_q  input  DATA_W  memory read data, valid one clock after the address is sampled.
REQ-014 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states: IDLE, ACCESS, RDATA; at most one transaction in flight.
REQ-016 IDLE: the FSM samples core_req and ext_req; if neither is high, it stays in IDLE.
REQ-017 IDLE, at least one request: the FSM picks a winner, latches its we/addr/wdata and winner id, and moves to ACCESS.
REQ-018 ACCESS lasts exactly one cycle: the winner's gnt=1 and mem_address/mem_data come from the latches.
REQ-019 ACCESS, mem_wren: equals the latched we and is 0 in every other state.
REQ-020 ACCESS exit: a write returns to IDLE; a read goes to RDATA.
REQ-021 RDATA lasts one cycle: the winner's rvalid=1 and its rdata=mem_q; the FSM then returns to IDLE.
REQ-022 Latency from req sampled in IDLE: write gnt at +1 cycle; read gnt at +1 and rvalid at +2; minimum spacing between grants is 2 cycles for writes and 3 for reads.
REQ-023 Request hold: a requester holds req and its fields stable until gnt; req still high in the IDLE after gnt is a new transaction.
REQ-024 Non-granted outputs: gnt and rvalid are never high for both ports in the same cycle, and never high for the non-winner.
REQ-025 Input changes during ACCESS/RDATA: changes on req, addr or wdata have no effect on the in-flight transaction.
REQ-026 Idle outputs: mem_address and mem_data hold their last latched value when idle.

Reset
REQ-027 Reset values: rst_n low forces state=IDLE; all gnt, rvalid, mem_wren and busy = 0; all rdata, mem_address and mem_data = 0; last-winner = ext.
REQ-028 Reset mid-transaction: the in-flight transaction is discarded with no rvalid; a write in ACCESS is aborted if reset asserts before the clock edge.
REQ-029 Reset release: the first sampled IDLE cycle after deassertion arbitrates normally.

Configuration
REQ-030 Macro: DMEM_ARB_ROUND_ROBIN_EN.
REQ-031 Macro defined: simultaneous requests go to the port that did not win last; last-winner updates on every grant.
REQ-032 Macro undefined: fixed priority, core always wins ties; last-winner is not implemented; ext is served only when core_req=0 in IDLE.

Verification
REQ-033 Core write: core_req=1, we=1, addr=0x005, wdata=0xDEADBEEF -> next cycle core_gnt=1, mem_wren=1, mem_address=0x005, mem_data=0xDEADBEEF; IDLE the cycle after.
REQ-034 Ext read: after the write, ext_req=1, we=0, addr=0x005 -> ext_gnt at +1, ext_rvalid=1 with ext_rdata=0xDEADBEEF at +2, core outputs stay 0.
REQ-035 Tie from reset, round-robin build: both ports request reads, held high -> grants in order core, ext, core, ext, each grant 3 cycles apart.
REQ-036 Tie, fixed-priority build: same stimulus -> core_gnt every 3 cycles, ext_gnt never while core_req=1, ext granted on the first IDLE after core_req drops.
REQ-037 Reset mid-read: assert rst_n=0 in ACCESS of a read -> no rvalid; busy=0 and all outputs 0 during reset; a subsequent core write completes per REQ-033.
REQ-038 Field change after grant: change core_addr to 0x3FF during RDATA -> rdata still reflects the originally latched address.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: core port, external loader port and memory port.
// slave = arbiter side, master = requesters/memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_address, mem_data, mem_wren,
    input  mem_q
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_address, mem_data, mem_wren,
    output mem_q
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory, one transaction in flight.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties; default build is fixed priority (core wins).
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

  state_t            state, state_nxt;
  logic              any_req;
  logic              win_ext;
  logic              lat_ext;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  assign any_req = bus.core_req | bus.ext_req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // last_ext resets to 1 so the first tie after reset goes to the core
  logic last_ext;

  always_comb win_ext = bus.ext_req & (~bus.core_req | ~last_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       last_ext <= 1'b1;
    else if (state == IDLE && any_req) last_ext <= win_ext;
  end
`else
  always_comb win_ext = bus.ext_req & ~bus.core_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_ext   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      lat_ext   <= win_ext;
      lat_we    <= win_ext ? bus.ext_we    : bus.core_we;
      lat_addr  <= win_ext ? bus.ext_addr  : bus.core_addr;
      lat_wdata <= win_ext ? bus.ext_wdata : bus.core_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = lat_we ? IDLE : RDATA;
      RDATA:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.core_gnt    = 1'b0;
    bus.core_rvalid = 1'b0;
    bus.core_rdata  = '0;
    bus.ext_gnt     = 1'b0;
    bus.ext_rvalid  = 1'b0;
    bus.ext_rdata   = '0;
    bus.mem_wren    = 1'b0;
    bus.mem_address = lat_addr;
    bus.mem_data    = lat_wdata;
    busy            = (state != IDLE);
    case (state)
      ACCESS: begin
        bus.core_gnt = ~lat_ext;
        bus.ext_gnt  = lat_ext;
        bus.mem_wren = lat_we;
      end
      RDATA: begin
        bus.core_rvalid = ~lat_ext;
        bus.ext_rvalid  = lat_ext;
        if (lat_ext) bus.ext_rdata  = bus.mem_q;
        else         bus.core_rdata = bus.mem_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural synchronous memory.
// Honours DMEM_ARB_ROUND_ROBIN_EN to select the tie-break expectations.
module tb_dmem_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic clk;
  logic rst_n;
  logic busy;
  int   total;
  int   bad;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (bus.mem_wren) mem[bus.mem_address] <= bus.mem_data;
    bus.mem_q <= mem[bus.mem_address];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total += 8;
    if (busy !== 1'b0)            begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (bus.core_gnt !== 1'b0)    begin bad++; $display("FAIL rst_core_gnt: got %b expected 0", bus.core_gnt); end
    if (bus.ext_gnt !== 1'b0)     begin bad++; $display("FAIL rst_ext_gnt: got %b expected 0", bus.ext_gnt); end
    if (bus.core_rvalid !== 1'b0) begin bad++; $display("FAIL rst_core_rvalid: got %b expected 0", bus.core_rvalid); end
    if (bus.ext_rvalid !== 1'b0)  begin bad++; $display("FAIL rst_ext_rvalid: got %b expected 0", bus.ext_rvalid); end
    if (bus.mem_wren !== 1'b0)    begin bad++; $display("FAIL rst_mem_wren: got %b expected 0", bus.mem_wren); end
    if (bus.mem_address !== '0)   begin bad++; $display("FAIL rst_mem_address: got %h expected 0", bus.mem_address); end
    if (bus.mem_data !== '0)      begin bad++; $display("FAIL rst_mem_data: got %h expected 0", bus.mem_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_core_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = a; bus.core_wdata = d;
    @(negedge clk);
    total += 6;
    if (bus.core_gnt !== 1'b1)  begin bad++; $display("FAIL wr_core_gnt: got %b expected 1", bus.core_gnt); end
    if (bus.ext_gnt !== 1'b0)   begin bad++; $display("FAIL wr_ext_gnt: got %b expected 0", bus.ext_gnt); end
    if (bus.mem_wren !== 1'b1)  begin bad++; $display("FAIL wr_mem_wren: got %b expected 1", bus.mem_wren); end
    if (bus.mem_address !== a)  begin bad++; $display("FAIL wr_mem_address: got %h expected %h", bus.mem_address, a); end
    if (bus.mem_data !== d)     begin bad++; $display("FAIL wr_mem_data: got %h expected %h", bus.mem_data, d); end
    if (busy !== 1'b1)          begin bad++; $display("FAIL wr_busy: got %b expected 1", busy); end
    bus.core_req = 1'b0;
    @(negedge clk);
    total += 4;
    if (busy !== 1'b0)          begin bad++; $display("FAIL wr_idle_busy: got %b expected 0", busy); end
    if (bus.core_gnt !== 1'b0)  begin bad++; $display("FAIL wr_idle_gnt: got %b expected 0", bus.core_gnt); end
    if (bus.mem_wren !== 1'b0)  begin bad++; $display("FAIL wr_idle_wren: got %b expected 0", bus.mem_wren); end
    if (bus.mem_address !== a)  begin bad++; $display("FAIL wr_idle_addr_hold: got %h expected %h", bus.mem_address, a); end
  endtask

  task automatic test_ext_read();
    @(negedge clk);
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 10'h005; bus.ext_wdata = 32'h0;
    @(negedge clk);
    total += 4;
    if (bus.ext_gnt !== 1'b1)         begin bad++; $display("FAIL rd_ext_gnt: got %b expected 1", bus.ext_gnt); end
    if (bus.core_gnt !== 1'b0)        begin bad++; $display("FAIL rd_core_gnt: got %b expected 0", bus.core_gnt); end
    if (bus.mem_wren !== 1'b0)        begin bad++; $display("FAIL rd_mem_wren: got %b expected 0", bus.mem_wren); end
    if (bus.mem_address !== 10'h005)  begin bad++; $display("FAIL rd_mem_address: got %h expected 005", bus.mem_address); end
    bus.ext_req = 1'b0;
    @(negedge clk);
    total += 4;
    if (bus.ext_rvalid !== 1'b1)           begin bad++; $display("FAIL rd_ext_rvalid: got %b expected 1", bus.ext_rvalid); end
    if (bus.ext_rdata !== 32'hDEADBEEF)    begin bad++; $display("FAIL rd_ext_rdata: got %h expected deadbeef", bus.ext_rdata); end
    if (bus.core_rvalid !== 1'b0)          begin bad++; $display("FAIL rd_core_rvalid: got %b expected 0", bus.core_rvalid); end
    if (bus.core_rdata !== '0)             begin bad++; $display("FAIL rd_core_rdata: got %h expected 0", bus.core_rdata); end
    @(negedge clk);
    total += 2;
    if (busy !== 1'b0)            begin bad++; $display("FAIL rd_idle_busy: got %b expected 0", busy); end
    if (bus.ext_rvalid !== 1'b0)  begin bad++; $display("FAIL rd_idle_rvalid: got %b expected 0", bus.ext_rvalid); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 10'h007; bus.core_wdata = 32'hAAAA0001;
    @(negedge clk);
    total++;
    if (bus.core_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt0: got %b expected 1", bus.core_gnt); end
    @(negedge clk);
    total++;
    if (bus.core_gnt !== 1'b0) begin bad++; $display("FAIL b2b_gap: got %b expected 0", bus.core_gnt); end
    bus.core_wdata = 32'hBBBB0002;
    @(negedge clk);
    total += 2;
    if (bus.core_gnt !== 1'b1)           begin bad++; $display("FAIL b2b_gnt1: got %b expected 1", bus.core_gnt); end
    if (bus.mem_data !== 32'hBBBB0002)   begin bad++; $display("FAIL b2b_data1: got %h expected bbbb0002", bus.mem_data); end
    bus.core_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_field_change();
    test_core_write(10'h3FF, 32'h0BADF00D);
    @(negedge clk);
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 10'h005;
    @(negedge clk);
    total++;
    if (bus.core_gnt !== 1'b1) begin bad++; $display("FAIL fc_gnt: got %b expected 1", bus.core_gnt); end
    bus.core_addr = 10'h3FF;
    @(negedge clk);
    bus.core_addr = 10'h3FF;
    #1;
    total += 3;
    if (bus.core_rvalid !== 1'b1)         begin bad++; $display("FAIL fc_rvalid: got %b expected 1", bus.core_rvalid); end
    if (bus.core_rdata !== 32'hDEADBEEF)  begin bad++; $display("FAIL fc_rdata: got %h expected deadbeef", bus.core_rdata); end
    if (bus.mem_address !== 10'h005)      begin bad++; $display("FAIL fc_addr_hold: got %h expected 005", bus.mem_address); end
    bus.core_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie();
    logic w_ext, exp_cg, exp_eg, exp_cr, exp_er;
    int   k;
    test_reset();
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 10'h010;
    bus.ext_req  = 1'b1; bus.ext_we  = 1'b0; bus.ext_addr  = 10'h020;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      k = (c - 1) / 3;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      w_ext = (k % 2) == 1;
`else
      w_ext = (k == 3);
`endif
      exp_cg = (c % 3 == 1) && !w_ext;
      exp_eg = (c % 3 == 1) &&  w_ext;
      exp_cr = (c % 3 == 2) && !w_ext;
      exp_er = (c % 3 == 2) &&  w_ext;
      total += 4;
      if (bus.core_gnt !== exp_cg)   begin bad++; $display("FAIL tie_core_gnt c=%0d: got %b expected %b", c, bus.core_gnt, exp_cg); end
      if (bus.ext_gnt !== exp_eg)    begin bad++; $display("FAIL tie_ext_gnt c=%0d: got %b expected %b", c, bus.ext_gnt, exp_eg); end
      if (bus.core_rvalid !== exp_cr) begin bad++; $display("FAIL tie_core_rvalid c=%0d: got %b expected %b", c, bus.core_rvalid, exp_cr); end
      if (bus.ext_rvalid !== exp_er) begin bad++; $display("FAIL tie_ext_rvalid c=%0d: got %b expected %b", c, bus.ext_rvalid, exp_er); end
`ifndef DMEM_ARB_ROUND_ROBIN_EN
      if (c == 8) bus.core_req = 1'b0;
`endif
      if (c == 10) begin bus.core_req = 1'b0; bus.ext_req = 1'b0; end
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL tie_end_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 10'h005;
    @(negedge clk);
    total++;
    if (bus.core_gnt !== 1'b1) begin bad++; $display("FAIL mr_gnt: got %b expected 1", bus.core_gnt); end
    bus.core_req = 1'b0;
    rst_n = 1'b0;
    #1;
    total += 5;
    if (busy !== 1'b0)            begin bad++; $display("FAIL mr_busy: got %b expected 0", busy); end
    if (bus.core_gnt !== 1'b0)    begin bad++; $display("FAIL mr_gnt_rst: got %b expected 0", bus.core_gnt); end
    if (bus.mem_address !== '0)   begin bad++; $display("FAIL mr_mem_address: got %h expected 0", bus.mem_address); end
    if (bus.mem_data !== '0)      begin bad++; $display("FAIL mr_mem_data: got %h expected 0", bus.mem_data); end
    if (bus.core_rvalid !== 1'b0) begin bad++; $display("FAIL mr_rvalid0: got %b expected 0", bus.core_rvalid); end
    @(negedge clk);
    total += 2;
    if (bus.core_rvalid !== 1'b0) begin bad++; $display("FAIL mr_rvalid1: got %b expected 0", bus.core_rvalid); end
    if (busy !== 1'b0)            begin bad++; $display("FAIL mr_busy1: got %b expected 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.core_rvalid !== 1'b0) begin bad++; $display("FAIL mr_rvalid2: got %b expected 0", bus.core_rvalid); end
    test_core_write(10'h005, 32'hDEADBEEF);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.ext_req  = 1'b0; bus.ext_we  = 1'b0; bus.ext_addr  = '0; bus.ext_wdata  = '0;
    test_reset();
    test_core_write(10'h005, 32'hDEADBEEF);
    test_ext_read();
    test_back_to_back();
    test_field_change();
    test_tie();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
